ex_ctrl_pipe: RTL and testbench
===============================

EX_CTRL_PIPE -- requirements
Module: ex_ctrl_pipe

Interface
REQ-001 Parameter DEPTH, default 3, number of register stages between input and output (legal 1..8).
REQ-002 Parameter OCC_W, default 4, width of occ_o; SHALL be at least clog2(DEPTH+1).
REQ-003 clk  in  1  clock; reset rst, synchronous, active-high; clock clk.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 stall_i  in  1  hold all stages; ignore input this cycle.
REQ-006 flush_i  in  1  invalidate all in-flight stages.
REQ-007 valid_i  in  1  input bundle carries a real instruction.
REQ-008 dm_re_i, regfile_we_w_i, regfile_we_uhw_i, branchen_i, sr_we_i  in  1 each  control enables.
REQ-009 addr_rd_i  in  reg_addr_width; condcode_i  in  cond_code_width; branchtrgt_i  in  im_addr_width.
REQ-010 rs_a_i, rs_b_i  in  reg_addr_width  source registers queried for hazards.
REQ-011 valid_o plus dm_re_o, addr_rd_o, regfile_we_w_o, regfile_we_uhw_o, branchen_o, condcode_o, branchtrgt_o, sr_we_o  out  widths as inputs  final-stage bundle.
REQ-012 hazard_a_o, hazard_b_o  out  1  in-flight writer matches rs_a_i / rs_b_i.
REQ-013 occ_o  out  OCC_W  number of valid stages; busy_o  out  1  occ_o != 0.

Function
REQ-014 Each stage SHALL hold a valid bit plus the full bundle; stage 0 is input side, stage DEPTH-1 drives outputs.
REQ-015 With stall_i=0, flush_i=0: stage0 <= {valid_i, inputs}, stage k <= stage k-1 every cycle; latency exactly DEPTH cycles.
REQ-016 With stall_i=1, flush_i=0: every stage, valid bit and occ_o SHALL hold; inputs are dropped.
REQ-017 flush_i=1 SHALL clear every valid bit next cycle and drop the input, regardless of stall_i (flush wins).
REQ-018 Enable outputs (dm_re_o, regfile_we_w_o, regfile_we_uhw_o, branchen_o, sr_we_o) SHALL be gated by the final-stage valid bit; addr_rd_o, condcode_o, branchtrgt_o pass raw.
REQ-019 An input with valid_i=0 SHALL enter as a bubble: its enables never reach the outputs.
REQ-020 hazard_a_o SHALL be 1 iff some stage k (0..DEPTH-1) is valid, has regfile_we_w or regfile_we_uhw set, and addr_rd == rs_a_i; likewise hazard_b_o with rs_b_i.
REQ-021 Hazard outputs SHALL be combinational from registered state and rs inputs only (no path from *_i bundle inputs).
REQ-022 occ_o SHALL be a registered counter: +1 when a valid input enters and the final stage does not hold a valid entry leaving, -1 when the final valid entry leaves and no valid input enters, unchanged otherwise; 0 after flush.
REQ-023 occ_o SHALL always equal the population count of the valid bits; it never exceeds DEPTH and never wraps.
REQ-024 DEPTH=1 SHALL behave as a single registered stage with identical stall/flush/hazard rules.

Reset
REQ-025 rst SHALL clear all valid bits, all stage payloads, all outputs and occ_o to 0 on the next clk edge; rst has priority over flush_i and stall_i.
REQ-026 rst asserted mid-stream SHALL discard all in-flight entries; no enable output is 1 in the cycle after reset.

Structure
REQ-027 reg_addr_width, cond_code_width, im_addr_width and the bundle record type SHALL come from the shared defines package; no local redefinition.
REQ-028 One sub-module, ex_ctrl_stage (single valid+bundle register with stall/flush), SHALL be instantiated DEPTH times via generate.

Verification
REQ-029 DEPTH=3, valid bundle addr_rd=5, we_w=1 at cycle 0 -> valid_o=1, addr_rd_o=5, regfile_we_w_o=1 at cycle 3 only.
REQ-030 Stream of 3 valid entries, stall_i=1 for 2 cycles at cycle 1 -> outputs delayed 2 cycles, order preserved, occ_o holds during stall.
REQ-031 Pipe full (occ_o=3), flush_i=1 and stall_i=1 together -> next cycle occ_o=0, busy_o=0, all enable outputs 0.
REQ-032 Entry addr_rd=7 we_uhw=1 in stage 1, rs_a_i=7, rs_b_i=2 -> hazard_a_o=1, hazard_b_o=0; same entry with valid=0 -> hazard_a_o=0.
REQ-033 valid_i=0 with dm_re_i=1, sr_we_i=1 -> after 3 cycles dm_re_o=0, sr_we_o=0, occ_o unchanged.
REQ-034 rst asserted while occ_o=2 -> next cycle all outputs 0, occ_o=0; first post-reset entry emerges after exactly DEPTH cycles.

Source files
------------

// File: rtl/ex_ctrl_pipe_pkg.sv
// Purpose: shared field widths and the EX control bundle record.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ex_ctrl_pipe_pkg;

    localparam int reg_addr_width  = 5;
    localparam int cond_code_width = 4;
    localparam int im_addr_width   = 16;

    // Everything the EX stage hands downstream for one instruction.
    typedef struct packed {
        logic                       dm_re;
        logic [reg_addr_width-1:0]  addr_rd;
        logic                       regfile_we_w;
        logic                       regfile_we_uhw;
        logic                       branchen;
        logic [cond_code_width-1:0] condcode;
        logic [im_addr_width-1:0]   branchtrgt;
        logic                       sr_we;
    } ex_ctrl_t;

endpackage

// File: rtl/ex_ctrl_stage.sv
// Purpose: one valid bit plus control bundle register.
// Latency: 1 cycle.
// Backpressure: stall_i holds contents and drops input; flush_i clears valid and wins over stall.
module ex_ctrl_stage
    import ex_ctrl_pipe_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     stall_i,
    input  logic     flush_i,
    input  logic     valid_i,
    input  ex_ctrl_t bundle_i,
    output logic     valid_o,
    output ex_ctrl_t bundle_o
);

    logic     valid_d, valid_q;
    ex_ctrl_t bundle_d, bundle_q;

    // Next state: flush kills the entry, stall holds, otherwise capture upstream.
    always_comb begin
        valid_d  = valid_q;
        bundle_d = bundle_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (!stall_i) begin
            valid_d  = valid_i;
            bundle_d = bundle_i;
        end
    end

    // Stage register; reset also clears the payload so raw fields read 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= 1'b0;
            bundle_q <= '0;
        end else begin
            valid_q  <= valid_d;
            bundle_q <= bundle_d;
        end
    end

    assign valid_o  = valid_q;
    assign bundle_o = bundle_q;

endmodule

// File: rtl/ex_ctrl_pipe.sv
// Purpose: DEPTH-stage control delay line with write-back hazard detection and occupancy count.
// Latency: exactly DEPTH cycles from input to output when not stalled.
// Backpressure: stall_i freezes every stage and drops the input; flush_i empties the pipe.
module ex_ctrl_pipe
    import ex_ctrl_pipe_pkg::*;
#(
    parameter int DEPTH = 3,
    parameter int OCC_W = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       stall_i,
    input  logic                       flush_i,
    input  logic                       valid_i,
    input  logic                       dm_re_i,
    input  logic [reg_addr_width-1:0]  addr_rd_i,
    input  logic                       regfile_we_w_i,
    input  logic                       regfile_we_uhw_i,
    input  logic                       branchen_i,
    input  logic [cond_code_width-1:0] condcode_i,
    input  logic [im_addr_width-1:0]   branchtrgt_i,
    input  logic                       sr_we_i,
    input  logic [reg_addr_width-1:0]  rs_a_i,
    input  logic [reg_addr_width-1:0]  rs_b_i,
    output logic                       valid_o,
    output logic                       dm_re_o,
    output logic [reg_addr_width-1:0]  addr_rd_o,
    output logic                       regfile_we_w_o,
    output logic                       regfile_we_uhw_o,
    output logic                       branchen_o,
    output logic [cond_code_width-1:0] condcode_o,
    output logic [im_addr_width-1:0]   branchtrgt_o,
    output logic                       sr_we_o,
    output logic                       hazard_a_o,
    output logic                       hazard_b_o,
    output logic [OCC_W-1:0]           occ_o,
    output logic                       busy_o
);

    ex_ctrl_t         in_dat;
    ex_ctrl_t         stg_dat [DEPTH];
    logic [DEPTH-1:0] stg_vld;
    ex_ctrl_t         last_dat;
    logic             last_vld;
    logic [OCC_W-1:0] occ_d, occ_q;

    assign in_dat.dm_re          = dm_re_i;
    assign in_dat.addr_rd        = addr_rd_i;
    assign in_dat.regfile_we_w   = regfile_we_w_i;
    assign in_dat.regfile_we_uhw = regfile_we_uhw_i;
    assign in_dat.branchen       = branchen_i;
    assign in_dat.condcode       = condcode_i;
    assign in_dat.branchtrgt     = branchtrgt_i;
    assign in_dat.sr_we          = sr_we_i;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        if (k == 0) begin : g_head
            ex_ctrl_stage u_stage (
                .clk      (clk),
                .rst      (rst),
                .stall_i  (stall_i),
                .flush_i  (flush_i),
                .valid_i  (valid_i),
                .bundle_i (in_dat),
                .valid_o  (stg_vld[k]),
                .bundle_o (stg_dat[k])
            );
        end else begin : g_body
            ex_ctrl_stage u_stage (
                .clk      (clk),
                .rst      (rst),
                .stall_i  (stall_i),
                .flush_i  (flush_i),
                .valid_i  (stg_vld[k-1]),
                .bundle_i (stg_dat[k-1]),
                .valid_o  (stg_vld[k]),
                .bundle_o (stg_dat[k])
            );
        end
    end

    assign last_dat = stg_dat[DEPTH-1];
    assign last_vld = stg_vld[DEPTH-1];

    // Enables only count when the final entry is real; data fields pass raw.
    assign valid_o          = last_vld;
    assign dm_re_o          = last_vld & last_dat.dm_re;
    assign regfile_we_w_o   = last_vld & last_dat.regfile_we_w;
    assign regfile_we_uhw_o = last_vld & last_dat.regfile_we_uhw;
    assign branchen_o       = last_vld & last_dat.branchen;
    assign sr_we_o          = last_vld & last_dat.sr_we;
    assign addr_rd_o        = last_dat.addr_rd;
    assign condcode_o       = last_dat.condcode;
    assign branchtrgt_o     = last_dat.branchtrgt;

    // Hazard: any valid in-flight register writer targeting a queried source.
    always_comb begin
        hazard_a_o = 1'b0;
        hazard_b_o = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if (stg_vld[k] && (stg_dat[k].regfile_we_w || stg_dat[k].regfile_we_uhw)) begin
                if (stg_dat[k].addr_rd == rs_a_i) hazard_a_o = 1'b1;
                if (stg_dat[k].addr_rd == rs_b_i) hazard_b_o = 1'b1;
            end
        end
    end

    // Occupancy tracks valid entries in minus valid entries out when the pipe advances.
    always_comb begin
        occ_d = occ_q;
        if (flush_i) begin
            occ_d = '0;
        end else if (!stall_i) begin
            occ_d = occ_q + OCC_W'(valid_i) - OCC_W'(last_vld);
        end
    end

    // Occupancy register.
    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign occ_o  = occ_q;
    assign busy_o = (occ_q != '0);

endmodule

// File: tb/tb_ex_ctrl_pipe.sv
// Purpose: directed self-checking bench for ex_ctrl_pipe at DEPTH=3.
// Latency: checks outputs 1 time unit after each rising edge.
// Backpressure: exercises stall, flush, combined stall+flush and mid-stream reset.
module tb_ex_ctrl_pipe;

    logic        clk;
    logic        rst;
    logic        stall_i;
    logic        flush_i;
    logic        valid_i;
    logic        dm_re_i;
    logic [4:0]  addr_rd_i;
    logic        regfile_we_w_i;
    logic        regfile_we_uhw_i;
    logic        branchen_i;
    logic [3:0]  condcode_i;
    logic [15:0] branchtrgt_i;
    logic        sr_we_i;
    logic [4:0]  rs_a_i;
    logic [4:0]  rs_b_i;
    logic        valid_o;
    logic        dm_re_o;
    logic [4:0]  addr_rd_o;
    logic        regfile_we_w_o;
    logic        regfile_we_uhw_o;
    logic        branchen_o;
    logic [3:0]  condcode_o;
    logic [15:0] branchtrgt_o;
    logic        sr_we_o;
    logic        hazard_a_o;
    logic        hazard_b_o;
    logic [3:0]  occ_o;
    logic        busy_o;

    int n_vec = 0;
    int n_err = 0;

    ex_ctrl_pipe #(.DEPTH(3), .OCC_W(4)) dut (
        .clk              (clk),
        .rst              (rst),
        .stall_i          (stall_i),
        .flush_i          (flush_i),
        .valid_i          (valid_i),
        .dm_re_i          (dm_re_i),
        .addr_rd_i        (addr_rd_i),
        .regfile_we_w_i   (regfile_we_w_i),
        .regfile_we_uhw_i (regfile_we_uhw_i),
        .branchen_i       (branchen_i),
        .condcode_i       (condcode_i),
        .branchtrgt_i     (branchtrgt_i),
        .sr_we_i          (sr_we_i),
        .rs_a_i           (rs_a_i),
        .rs_b_i           (rs_b_i),
        .valid_o          (valid_o),
        .dm_re_o          (dm_re_o),
        .addr_rd_o        (addr_rd_o),
        .regfile_we_w_o   (regfile_we_w_o),
        .regfile_we_uhw_o (regfile_we_uhw_o),
        .branchen_o       (branchen_o),
        .condcode_o       (condcode_o),
        .branchtrgt_o     (branchtrgt_o),
        .sr_we_o          (sr_we_o),
        .hazard_a_o       (hazard_a_o),
        .hazard_b_o       (hazard_b_o),
        .occ_o            (occ_o),
        .busy_o           (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] addr, input logic [4:0] en);
        valid_i          = v;
        addr_rd_i        = addr;
        dm_re_i          = en[4];
        regfile_we_w_i   = en[3];
        regfile_we_uhw_i = en[2];
        branchen_i       = en[1];
        sr_we_i          = en[0];
        condcode_i       = 4'ha;
        branchtrgt_i     = 16'h1234;
    endtask

    function automatic logic [4:0] enables();
        return {dm_re_o, regfile_we_w_o, regfile_we_uhw_o, branchen_o, sr_we_o};
    endfunction

    initial begin
        rst = 1'b1; stall_i = 1'b0; flush_i = 1'b0;
        rs_a_i = 5'd0; rs_b_i = 5'd0;
        drive(1'b0, 5'd0, 5'b00000);
        tick();
        tick();
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_occ",   32'(occ_o),   32'd0);
        check("rst_busy",  32'(busy_o),  32'd0);
        check("rst_en",    32'(enables()), 32'd0);
        check("rst_haz",   32'({hazard_a_o, hazard_b_o}), 32'd0);
        rst = 1'b0;

        // Single entry, latency exactly 3.
        drive(1'b1, 5'd5, 5'b01000);
        tick();
        check("lat_c1_valid", 32'(valid_o), 32'd0);
        check("lat_c1_occ",   32'(occ_o),   32'd1);
        drive(1'b0, 5'd0, 5'b00000);
        tick();
        check("lat_c2_valid", 32'(valid_o), 32'd0);
        tick();
        check("lat_c3_valid", 32'(valid_o), 32'd1);
        check("lat_c3_addr",  32'(addr_rd_o), 32'd5);
        check("lat_c3_we_w",  32'(regfile_we_w_o), 32'd1);
        check("lat_c3_cc",    32'(condcode_o), 32'ha);
        check("lat_c3_trgt",  32'(branchtrgt_o), 32'h1234);
        tick();
        check("lat_c4_valid", 32'(valid_o), 32'd0);
        check("lat_c4_occ",   32'(occ_o),   32'd0);

        // Three entries with a two-cycle stall after the first.
        drive(1'b1, 5'd1, 5'b01000);
        tick();
        stall_i = 1'b1;
        drive(1'b1, 5'd2, 5'b01000);
        tick();
        check("stl_t2_occ", 32'(occ_o), 32'd1);
        tick();
        check("stl_t3_occ", 32'(occ_o), 32'd1);
        check("stl_t3_valid", 32'(valid_o), 32'd0);
        stall_i = 1'b0;
        tick();
        check("stl_t4_occ", 32'(occ_o), 32'd2);
        drive(1'b1, 5'd3, 5'b01000);
        tick();
        check("stl_t5_valid", 32'(valid_o), 32'd1);
        check("stl_t5_addr",  32'(addr_rd_o), 32'd1);
        check("stl_t5_occ",   32'(occ_o), 32'd3);
        drive(1'b0, 5'd0, 5'b00000);
        tick();
        check("stl_t6_addr", 32'(addr_rd_o), 32'd2);
        check("stl_t6_occ",  32'(occ_o), 32'd2);
        tick();
        check("stl_t7_addr", 32'(addr_rd_o), 32'd3);
        check("stl_t7_valid", 32'(valid_o), 32'd1);
        tick();
        check("stl_t8_valid", 32'(valid_o), 32'd0);
        check("stl_t8_occ",   32'(occ_o), 32'd0);

        // Fill, run one enter+leave cycle, then flush together with stall.
        drive(1'b1, 5'd9, 5'b11111);
        for (int i = 0; i < 3; i++) tick();
        check("full_occ", 32'(occ_o), 32'd3);
        check("full_en",  32'(enables()), 32'h1f);
        tick();
        check("full_swap_occ", 32'(occ_o), 32'd3);
        stall_i = 1'b1; flush_i = 1'b1;
        tick();
        check("flush_occ",   32'(occ_o), 32'd0);
        check("flush_busy",  32'(busy_o), 32'd0);
        check("flush_valid", 32'(valid_o), 32'd0);
        check("flush_en",    32'(enables()), 32'd0);
        stall_i = 1'b0; flush_i = 1'b0;

        // Hazard from a uhw writer to r7 as it moves through stages 0 and 1.
        rs_a_i = 5'd7; rs_b_i = 5'd2;
        drive(1'b1, 5'd7, 5'b00100);
        tick();
        drive(1'b0, 5'd0, 5'b00000);
        check("haz_s0_a", 32'(hazard_a_o), 32'd1);
        tick();
        check("haz_s1_a", 32'(hazard_a_o), 32'd1);
        check("haz_s1_b", 32'(hazard_b_o), 32'd0);
        rs_b_i = 5'd7; rs_a_i = 5'd3;
        #1;
        check("haz_swap_a", 32'(hazard_a_o), 32'd0);
        check("haz_swap_b", 32'(hazard_b_o), 32'd1);
        tick();
        tick();
        check("haz_gone_b", 32'(hazard_b_o), 32'd0);
        rs_a_i = 5'd7; rs_b_i = 5'd2;
        drive(1'b0, 5'd7, 5'b00100);
        tick();
        drive(1'b0, 5'd0, 5'b00000);
        tick();
        check("haz_bubble_a", 32'(hazard_a_o), 32'd0);
        tick();
        tick();

        // Bubble carrying enables never asserts them at the output.
        drive(1'b0, 5'd4, 5'b10001);
        tick();
        drive(1'b0, 5'd0, 5'b00000);
        tick();
        tick();
        check("bub_en",  32'(enables()), 32'd0);
        check("bub_occ", 32'(occ_o), 32'd0);
        check("bub_valid", 32'(valid_o), 32'd0);

        // Mid-stream reset with two entries in flight; reset beats a valid input.
        drive(1'b1, 5'd6, 5'b11111);
        tick();
        tick();
        check("prerst_occ", 32'(occ_o), 32'd2);
        rst = 1'b1; flush_i = 1'b0; stall_i = 1'b0;
        tick();
        check("mrst_occ",   32'(occ_o), 32'd0);
        check("mrst_valid", 32'(valid_o), 32'd0);
        check("mrst_en",    32'(enables()), 32'd0);
        check("mrst_addr",  32'(addr_rd_o), 32'd0);
        check("mrst_trgt",  32'(branchtrgt_o), 32'd0);
        rst = 1'b0;
        drive(1'b1, 5'd9, 5'b01000);
        tick();
        drive(1'b0, 5'd0, 5'b00000);
        tick();
        check("post_c2_valid", 32'(valid_o), 32'd0);
        tick();
        check("post_c3_valid", 32'(valid_o), 32'd1);
        check("post_c3_addr",  32'(addr_rd_o), 32'd9);
        tick();
        check("post_c4_busy", 32'(busy_o), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
